axi_mem_slave: RTL and testbench

AXI4 responder (slave) terminating the accelerator's DMA master ports: services read bursts from the input DMA and write bursts from the output DMA against an internal word-addressed memory. Serves as the on-chip scratch memory for the matrix accelerator and as the memory model for block-level DMA benches. Read and write channels are independent and may be active simultaneously.

---
 rtl/axi_mem_pkg.sv | 39 +++
 rtl/axi_mem_array.sv | 46 ++++
 rtl/axi_mem_slave.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4 scratch-memory responder.
//   RESP_*  : AXI response codes
//   BURST_* : AXI burst type encodings
//   wstate_e / rstate_e : write and read channel FSM states
//   resp_sel / burst_ok : response priority and burst-type legality helpers
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // A decode error dominates a slave error.
  function automatic logic [1:0] resp_sel(input logic dec, input logic slv);
    if (dec)      return RESP_DECERR;
    else if (slv) return RESP_SLVERR;
    else          return RESP_OKAY;
  endfunction

  // Only FIXED and INCR are supported; WRAP and reserved run as INCR but are flagged.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed storage for axi_mem_slave.
//   clk, rst  : clock, synchronous active-high reset (read output register only)
//   we_i, waddr_i, wdata_i, wstrb_i : byte-strobed write port
//   re_i, raddr_i, rzero_i          : read port; the output register loads on re_i,
//                                     loading zero instead of memory when rzero_i
//   rdata_o   : registered read data, held while re_i is low
// A read and write of the same word in one cycle returns the old contents.
module axi_mem_array
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_WORDS  = 1024,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  input  logic                  rzero_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by an internal word memory; independent read and write
// channels that may run concurrently.
//   clk, rst              : clock, synchronous active-high reset
//   axi_aw*/axi_w*/axi_b* : write address, write data, write response channels
//   axi_ar*/axi_r*        : read address and read data channels
// Parameters: DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH, ID_WIDTH, MEM_WORDS, BASE_ADDR
// (byte address of word 0). All outputs are registered.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    ID_WIDTH   = 8,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   axi_awid,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic [2:0]            axi_awsize,
  input  logic [1:0]            axi_awburst,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic [STRB_WIDTH-1:0] axi_wstrb,
  input  logic                  axi_wlast,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [ID_WIDTH-1:0]   axi_bid,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ID_WIDTH-1:0]   axi_arid,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  input  logic [2:0]            axi_arsize,
  input  logic [1:0]            axi_arburst,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [ID_WIDTH-1:0]   axi_rid,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic                  axi_rvalid,
  input  logic                  axi_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  // Beat addresses carry one extra bit so that running past 2^ADDR_WIDTH stays out of range.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * STRB_WIDTH);
  localparam logic [ADDR_WIDTH:0] STEP      = (ADDR_WIDTH+1)'(STRB_WIDTH);
  localparam logic [2:0]          SIZE_FULL = 3'(ADDR_LSB);

  function automatic logic in_range(input logic [ADDR_WIDTH:0] a);
    logic [ADDR_WIDTH:0] off;
    off = a - BASE_EXT;
    return !a[ADDR_WIDTH] && (a >= BASE_EXT) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH:0] a);
    logic [ADDR_WIDTH:0] off;
    off = a - BASE_EXT;
    return IDX_W'(off >> ADDR_LSB);
  endfunction

  function automatic logic [ADDR_WIDTH:0] next_addr(input logic [ADDR_WIDTH:0] a,
                                                    input logic [1:0]        burst);
    logic [ADDR_WIDTH:0] n;
    if (burst == BURST_FIXED) begin
      n = a;
    end else begin
      n = a + STEP;
      n[ADDR_WIDTH] = n[ADDR_WIDTH] | a[ADDR_WIDTH];
    end
    return n;
  endfunction

  // ---------------- write channel state ----------------
  wstate_e               wstate_q, wstate_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d, wid_q, wid_d;
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  wsize_ok_q, wsize_ok_d, wslv_q, wslv_d, wdec_q, wdec_d;
  logic                  w_in_rng, w_dec, w_slv;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;

  // ---------------- read channel state ----------------
  rstate_e               rstate_q, rstate_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH:0]   raddr_q, raddr_d, r_addr;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]            rburst_q, rburst_d;
  logic                  rsize_ok_q, rsize_ok_d, rslv_q, rslv_d;
  logic                  r_in_rng, rd_en, rd_zero;
  logic [IDX_W-1:0]      rd_idx;

  assign w_in_rng = in_range(waddr_q);
  assign mem_widx = word_idx(waddr_q);

  // The first beat is looked up straight from the AR bus so rdata is ready the
  // cycle after the handshake; later beats come from the advanced address.
  assign r_addr   = (rstate_q == R_IDLE) ? {1'b0, axi_araddr} : raddr_q;
  assign r_in_rng = in_range(r_addr);
  assign rd_idx   = word_idx(r_addr);

  always_comb begin
    wstate_d   = wstate_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    bid_d      = bid_q;
    wid_d      = wid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    wburst_d   = wburst_q;
    wsize_ok_d = wsize_ok_q;
    wslv_d     = wslv_q;
    wdec_d     = wdec_q;
    w_dec      = wdec_q;
    w_slv      = wslv_q;
    mem_we     = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (axi_awvalid && awready_q) begin
          wstate_d   = W_DATA;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          wid_d      = axi_awid;
          waddr_d    = {1'b0, axi_awaddr};
          wlen_d     = axi_awlen;
          wcnt_d     = '0;
          wburst_d   = axi_awburst;
          wsize_ok_d = (axi_awsize == SIZE_FULL);
          wslv_d     = (axi_awsize != SIZE_FULL) || !burst_ok(axi_awburst);
          wdec_d     = 1'b0;
        end
      end
      W_DATA: begin
        if (axi_wvalid && wready_q) begin
          // A beat landing on the reset edge is dropped with the rest of the burst.
          mem_we  = w_in_rng && wsize_ok_q && !rst;
          w_dec   = wdec_q | !w_in_rng;
          w_slv   = wslv_q | (axi_wlast != (wcnt_q == wlen_q));
          wdec_d  = w_dec;
          wslv_d  = w_slv;
          waddr_d = next_addr(waddr_q, wburst_q);
          wcnt_d  = wcnt_q + 8'd1;
          if (wcnt_q == wlen_q) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = resp_sel(w_dec, w_slv);
            bid_d    = wid_q;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && axi_bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d   = rstate_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rcnt_d     = rcnt_q;
    rburst_d   = rburst_q;
    rsize_ok_d = rsize_ok_q;
    rslv_d     = rslv_q;
    rd_en      = 1'b0;
    rd_zero    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi_arvalid && arready_q) begin
          rstate_d   = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rid_d      = axi_arid;
          rlen_d     = axi_arlen;
          rcnt_d     = '0;
          rlast_d    = (axi_arlen == 8'd0);
          rburst_d   = axi_arburst;
          rsize_ok_d = (axi_arsize == SIZE_FULL);
          rslv_d     = (axi_arsize != SIZE_FULL) || !burst_ok(axi_arburst);
          rd_en      = 1'b1;
          rd_zero    = !(r_in_rng && (axi_arsize == SIZE_FULL));
          rresp_d    = resp_sel(!r_in_rng,
                                (axi_arsize != SIZE_FULL) || !burst_ok(axi_arburst));
          raddr_d    = next_addr({1'b0, axi_araddr}, axi_arburst);
        end
      end
      R_DATA: begin
        if (rvalid_q && axi_rready) begin
          if (rlast_q) begin
            rstate_d  = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            rd_en   = 1'b1;
            rd_zero = !(r_in_rng && rsize_ok_q);
            rresp_d = resp_sel(!r_in_rng, rslv_q);
            raddr_d = next_addr(raddr_q, rburst_q);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  // Burst bookkeeping is only meaningful inside a burst, so it is not reset.
  always_ff @(posedge clk) begin
    wid_q      <= wid_d;
    waddr_q    <= waddr_d;
    wlen_q     <= wlen_d;
    wcnt_q     <= wcnt_d;
    wburst_q   <= wburst_d;
    wsize_ok_q <= wsize_ok_d;
    wslv_q     <= wslv_d;
    wdec_q     <= wdec_d;
    raddr_q    <= raddr_d;
    rlen_q     <= rlen_d;
    rcnt_q     <= rcnt_d;
    rburst_q   <= rburst_d;
    rsize_ok_q <= rsize_ok_d;
    rslv_q     <= rslv_d;
  end

  axi_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (mem_widx),
    .wdata_i (axi_wdata),
    .wstrb_i (axi_wstrb),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rzero_i (rd_zero),
    .rdata_o (axi_rdata)
  );

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_bid     = bid_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rlast   = rlast_q;
  assign axi_rresp   = rresp_q;
  assign axi_rid     = rid_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: stimulus tasks push expected B and R
// responses into queues; independent monitors compare whenever the DUT presents them.
module tb_axi_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [7:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [7:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid, axi_arready;
  logic [7:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;

  axi_mem_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(8),
    .MEM_WORDS(1024), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int    checks = 0;
  int    errors = 0;
  bit    rr_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // R monitor: a presented beat must match the queue head whether or not it is accepted.
  always @(negedge clk) begin
    if (!rst && axi_rvalid) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected: got data %h id %h, expected no beat", axi_rdata, axi_rid);
      end else begin
        chk("rid",   32'(axi_rid),   32'(rq[0].id));
        chk("rdata", axi_rdata,      rq[0].data);
        chk("rresp", 32'(axi_rresp), 32'(rq[0].resp));
        chk("rlast", 32'(axi_rlast), 32'(rq[0].last));
        if (axi_rready) void'(rq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && axi_bvalid && axi_bready) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got bresp %h bid %h, expected no response", axi_bresp, axi_bid);
      end else begin
        chk("bid",   32'(axi_bid),   32'(bq[0].id));
        chk("bresp", 32'(axi_bresp), 32'(bq[0].resp));
        void'(bq.pop_front());
      end
    end
  end

  initial begin
    axi_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axi_rready = rr_toggle ? ~axi_rready : 1'b1;
    end
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake, expected one within 200 cycles", name);
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    logic hs = 1'b0;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = axi_awready; @(posedge clk); #1; n++;
    end
    axi_awvalid = 1'b0;
    if (!hs) timeout("aw_timeout");
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    logic hs = 1'b0;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = size; axi_arburst = burst;
    axi_arvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = axi_arready; @(posedge clk); #1; n++;
    end
    axi_arvalid = 1'b0;
    if (!hs) timeout("ar_timeout");
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    logic hs = 1'b0;
    axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk); hs = axi_wready; @(posedge clk); #1; n++;
    end
    axi_wvalid = 1'b0;
    if (!hs) timeout("w_timeout");
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                             input logic [3:0] strb, input logic bad_last, input logic [1:0] exp_resp);
    bexp_t e;
    e.id = id;
    e.resp = exp_resp;
    bq.push_back(e);
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++)
      w_beat(d0 + 32'(i), strb, (i == int'(len)) ^ bad_last);
  endtask

  task automatic exp_r(input logic [7:0] id, input logic [31:0] data, input logic [1:0] resp,
                       input logic last);
    rexp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  task automatic exp_seq(input logic [7:0] id, input logic [31:0] d0, input int len);
    for (int i = 0; i <= len; i++) exp_r(id, d0 + 32'(i), 2'b00, i == len);
  endtask

  task automatic drain;
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d R and %0d B pending, expected 0", rq.size(), bq.size());
      rq.delete();
      bq.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
    axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b1; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0;
    axi_arburst = '0; axi_arvalid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(axi_awready), 0);
    chk("rst_wready",  32'(axi_wready),  0);
    chk("rst_bvalid",  32'(axi_bvalid),  0);
    chk("rst_bresp",   32'(axi_bresp),   0);
    chk("rst_bid",     32'(axi_bid),     0);
    chk("rst_arready", 32'(axi_arready), 0);
    chk("rst_rvalid",  32'(axi_rvalid),  0);
    chk("rst_rlast",   32'(axi_rlast),   0);
    chk("rst_rresp",   32'(axi_rresp),   0);
    chk("rst_rid",     32'(axi_rid),     0);
    chk("rst_rdata",   axi_rdata,        0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_awready", 32'(axi_awready), 1);
    chk("post_rst_arready", 32'(axi_arready), 1);
    @(posedge clk); #1;

    // INCR write then read back
    write_burst(8'h5A, 32'h40, 8'd3, 3'd2, 2'b01, 32'd1, 4'hF, 1'b0, 2'b00);
    drain();
    exp_seq(8'h3C, 32'd1, 3);
    ar_send(8'h3C, 32'h40, 8'd3, 3'd2, 2'b01);
    drain();

    // Partial strobe merge
    write_burst(8'h01, 32'h10, 8'd0, 3'd2, 2'b01, 32'hAABBCCDD, 4'hF, 1'b0, 2'b00);
    write_burst(8'h02, 32'h10, 8'd0, 3'd2, 2'b01, 32'h11223344, 4'b0101, 1'b0, 2'b00);
    drain();
    exp_r(8'h03, 32'hAA22CC44, 2'b00, 1'b1);
    ar_send(8'h03, 32'h10, 8'd0, 3'd2, 2'b01);
    drain();

    // Out of range: first address past the memory aliases word 0 if decoding is wrong
    write_burst(8'h04, 32'h0, 8'd0, 3'd2, 2'b01, 32'h12345678, 4'hF, 1'b0, 2'b00);
    write_burst(8'h05, 32'h1000, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 1'b0, 2'b11);
    drain();
    exp_r(8'h06, 32'h0, 2'b11, 1'b1);
    ar_send(8'h06, 32'h1000, 8'd0, 3'd2, 2'b01);
    drain();
    exp_r(8'h07, 32'h12345678, 2'b00, 1'b1);
    ar_send(8'h07, 32'h0, 8'd0, 3'd2, 2'b01);
    drain();

    // Read backpressure with rready toggling
    write_burst(8'h10, 32'h200, 8'd7, 3'd2, 2'b01, 32'h100, 4'hF, 1'b0, 2'b00);
    drain();
    rr_toggle = 1'b1;
    exp_seq(8'h11, 32'h100, 7);
    ar_send(8'h11, 32'h200, 8'd7, 3'd2, 2'b01);
    drain();
    rr_toggle = 1'b0;

    // Write response backpressure
    axi_bready = 1'b0;
    write_burst(8'h21, 32'h300, 8'd0, 3'd2, 2'b01, 32'h55, 4'hF, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(axi_bvalid), 1);
      chk("awready_busy", 32'(axi_awready), 0);
      @(posedge clk); #1;
    end
    axi_bready = 1'b1;
    drain();

    // Concurrent read and write bursts
    write_burst(8'h30, 32'h0, 8'd15, 3'd2, 2'b01, 32'hA000, 4'hF, 1'b0, 2'b00);
    drain();
    fork
      write_burst(8'h31, 32'h100, 8'd15, 3'd2, 2'b01, 32'hB000, 4'hF, 1'b0, 2'b00);
      begin
        exp_seq(8'h32, 32'hA000, 15);
        ar_send(8'h32, 32'h0, 8'd15, 3'd2, 2'b01);
      end
    join
    drain();
    exp_seq(8'h33, 32'hB000, 15);
    ar_send(8'h33, 32'h100, 8'd15, 3'd2, 2'b01);
    drain();

    // FIXED burst: every beat hits the same word
    write_burst(8'h40, 32'h380, 8'd3, 3'd2, 2'b00, 32'hF0, 4'hF, 1'b0, 2'b00);
    drain();
    exp_r(8'h41, 32'hF3, 2'b00, 1'b1);
    ar_send(8'h41, 32'h380, 8'd0, 3'd2, 2'b01);
    drain();

    // WRAP runs as INCR with SLVERR
    write_burst(8'h50, 32'h390, 8'd1, 3'd2, 2'b10, 32'h61, 4'hF, 1'b0, 2'b10);
    drain();
    exp_seq(8'h51, 32'h61, 1);
    ar_send(8'h51, 32'h390, 8'd1, 3'd2, 2'b01);
    drain();

    // Bad size: write suppressed, read returns zero
    write_burst(8'h52, 32'h3A0, 8'd0, 3'd2, 2'b01, 32'h1111, 4'hF, 1'b0, 2'b00);
    write_burst(8'h53, 32'h3A0, 8'd0, 3'd1, 2'b01, 32'h9999, 4'hF, 1'b0, 2'b10);
    drain();
    exp_r(8'h54, 32'h1111, 2'b00, 1'b1);
    ar_send(8'h54, 32'h3A0, 8'd0, 3'd2, 2'b01);
    drain();
    exp_r(8'h55, 32'h0, 2'b10, 1'b1);
    ar_send(8'h55, 32'h40, 8'd0, 3'd1, 2'b01);
    drain();

    // wlast disagreeing with beat count
    write_burst(8'h56, 32'h3B0, 8'd1, 3'd2, 2'b01, 32'h71, 4'hF, 1'b1, 2'b10);
    drain();

    // Burst crossing the top of memory
    write_burst(8'h60, 32'hFFC, 8'd1, 3'd2, 2'b01, 32'h77, 4'hF, 1'b0, 2'b11);
    drain();
    exp_r(8'h61, 32'h77, 2'b00, 1'b0);
    exp_r(8'h61, 32'h0, 2'b11, 1'b1);
    ar_send(8'h61, 32'hFFC, 8'd1, 3'd2, 2'b01);
    drain();
    exp_r(8'h62, 32'hA000, 2'b00, 1'b1);
    ar_send(8'h62, 32'h0, 8'd0, 3'd2, 2'b01);
    drain();

    // Burst wrapping past the top of the address space
    exp_r(8'h63, 32'h0, 2'b11, 1'b0);
    exp_r(8'h63, 32'h0, 2'b11, 1'b1);
    ar_send(8'h63, 32'hFFFFFFFC, 8'd1, 3'd2, 2'b01);
    drain();

    // Reset during the third write beat
    aw_send(8'h70, 32'h3C0, 8'd3, 3'd2, 2'b01);
    w_beat(32'hC0, 4'hF, 1'b0);
    w_beat(32'hC1, 4'hF, 1'b0);
    axi_wdata = 32'hC2; axi_wstrb = 4'hF; axi_wlast = 1'b0; axi_wvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    axi_wvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_wready",  32'(axi_wready),  0);
    chk("rst_mid_bvalid",  32'(axi_bvalid),  0);
    chk("rst_mid_awready", 32'(axi_awready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rel_awready", 32'(axi_awready), 1);
    chk("rst_rel_wready",  32'(axi_wready),  0);
    @(posedge clk); #1;
    exp_seq(8'h71, 32'hC0, 1);
    ar_send(8'h71, 32'h3C0, 8'd1, 3'd2, 2'b01);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
